// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality rule used at acceptance time.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WB   = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_legal(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or
// zero-extends it according to the load funct3.
module load_extend
  import lsu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data = {24'b0, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data = {16'b0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, req/ack data bus with
// byte strobes, extended load writeback to the register file.
module load_store_unit
  import lsu_defs::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  adc_sck,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state, state_nxt;

  logic                  legal;
  logic                  timeout;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [4:0]            rd_q;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [3:0]            strb_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  assign legal   = req_legal(req_is_store, req_funct3, req_addr[1:0]);
  assign busy    = (state != ST_IDLE) || req_valid;
  assign timeout = (cnt == CNT_LAST);

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge adc_sck or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = legal ? ST_BUS : ST_ERR;
      ST_BUS: begin
        if (mem_ack)      state_nxt = is_store_q ? ST_IDLE : ST_WB;
        else if (timeout) state_nxt = ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Store lane placement; only sb/sh/sw reach acceptance for stores.
  always_comb begin
    strb_nxt  = 4'b1111;
    wdata_nxt = req_wdata;
    case (req_funct3)
      F3_B: begin
        strb_nxt  = 4'b0001 << req_addr[1:0];
        wdata_nxt = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        strb_nxt  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge adc_sck or negedge reset) begin
    if (!reset) begin
      done       <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      rd_q       <= '0;
      cnt        <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && legal) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            rd_q       <= req_rd;
            cnt        <= '0;
            mem_req    <= 1'b1;
            mem_we     <= req_is_store;
            mem_addr   <= {req_addr[DATA_WIDTH-1:2], 2'b00};
            mem_wstrb  <= req_is_store ? strb_nxt : 4'b0000;
            mem_wdata  <= wdata_nxt;
          end else if (req_valid) begin
            err <= 1'b1;
          end
        end
        ST_BUS: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ack || timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
          end
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            if (is_store_q) begin
              done <= 1'b1;
            end else begin
              wr_en   <= (rd_q != 5'd0);
              wr_addr <= rd_q;
              wr_data <= ext_data;
              done    <= 1'b1;
            end
          end else if (timeout) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a byte-level behavioural model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        adc_sck = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        busy, done, err, mem_req, mem_we, wr_en;
  logic [31:0] mem_addr, mem_wdata, wr_data;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [4:0]  wr_addr;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .adc_sck      (adc_sck),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 adc_sck = ~adc_sck;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of one access, gathered cycle by cycle.
  int          o_busy, o_req, o_done, o_done_cyc, o_err, o_err_cyc, o_wr;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data, o_maddr, o_mwdata;
  logic        o_mwe, o_unstable;
  logic [3:0]  o_mstrb;

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return ok && ((int'(a[1:0]) % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int bits;
    bits = ((1 << m_size(f3)) - 1) << a[1:0];
    return bits[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % m_size(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] lane, mask;
    int sz;
    sz   = m_size(f3);
    lane = rd >> (8 * int'(a[1:0]));
    if (sz >= 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    lane = lane & mask;
    if (!f3[2] && lane[8*sz-1]) lane = lane | ~mask;
    return lane;
  endfunction

  // ---------------- stimulus driver ----------------
  // ack_delay = number of BUS cycles before the ack cycle; negative = never ack.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [4:0] rd,
                            input logic [31:0] rdata, input int ack_delay);
    logic fin;
    o_busy = 0; o_req = 0; o_done = 0; o_done_cyc = -1; o_err = 0; o_err_cyc = -1;
    o_wr = 0; o_wr_addr = '0; o_wr_data = '0; o_maddr = '0; o_mwdata = '0;
    o_mwe = 1'b0; o_mstrb = '0; o_unstable = 1'b0;
    @(negedge adc_sck);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_rd = rd; mem_ack = 1'b0;
    #1;
    if (busy) o_busy++;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge adc_sck);
      req_valid = 1'b0;
      req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (mem_req) begin
        if (o_req == 0) begin
          o_maddr = mem_addr; o_mwe = mem_we; o_mstrb = mem_wstrb; o_mwdata = mem_wdata;
        end else if (mem_addr !== o_maddr || mem_we !== o_mwe ||
                     mem_wstrb !== o_mstrb || mem_wdata !== o_mwdata) begin
          o_unstable = 1'b1;
        end
        if (o_req == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        o_req++;
      end
      if (busy) o_busy++;
      if (done) begin o_done++; o_done_cyc = cyc; end
      if (err)  begin o_err++;  o_err_cyc = cyc; end
      if (wr_en) begin o_wr++; o_wr_addr = wr_addr; o_wr_data = wr_data; end
      if (!busy) fin = 1'b1;
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL access_bound: busy still %0b after 60 cycles, required 0", busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0;
    #12;
    n_cmp++;
    if ({mem_req, mem_we, wr_en, done, err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: req/we/wr_en/done/err=%b required 00000",
               {mem_req, mem_we, wr_en, done, err});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, wr_data, wr_addr, mem_wstrb} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h wdata=%h wr_data=%h wr_addr=%h strb=%b required zeros",
               mem_addr, mem_wdata, wr_data, wr_addr, mem_wstrb);
    end
    req_valid = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_hi: busy=%b required 1", busy); end
    req_valid = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_lo: busy=%b required 0", busy); end
    @(negedge adc_sck);
    reset = 1'b1;
  endtask

  task automatic test_lb_delayed();
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 32'h80FF_0011, 3);
    n_cmp++;
    if (o_maddr !== 32'h0000_0100) begin n_bad++; $display("FAIL lb_addr: got %h required 00000100", o_maddr); end
    n_cmp++;
    if (o_wr !== 1 || o_wr_addr !== 5'd5 || o_wr_data !== 32'hFFFF_FF80) begin
      n_bad++;
      $display("FAIL lb_write: count=%0d addr=%0d data=%h required 1/5/ffffff80", o_wr, o_wr_addr, o_wr_data);
    end
    n_cmp++;
    if (o_done !== 1 || o_done_cyc !== 5 || o_err !== 0 || o_req !== 4 || o_busy !== 6) begin
      n_bad++;
      $display("FAIL lb_timing: done=%0d@%0d err=%0d req=%0d busy=%0d required 1@5/0/4/6",
               o_done, o_done_cyc, o_err, o_req, o_busy);
    end
  endtask

  task automatic test_lhu_immediate();
    run_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd9, 32'h9ABC_1234, 0);
    n_cmp++;
    if (o_wr_data !== 32'h0000_9ABC || o_wr !== 1) begin
      n_bad++; $display("FAIL lhu_data: got %h (wr %0d) required 00009abc (wr 1)", o_wr_data, o_wr);
    end
    n_cmp++;
    if (o_busy !== 3) begin n_bad++; $display("FAIL lhu_busy: got %0d cycles required 3", o_busy); end
  endtask

  task automatic test_sh();
    run_access(1'b1, 3'b001, 32'h0000_0006, 32'h1234_5678, 5'd3, 32'h0, 0);
    n_cmp++;
    if (o_mstrb !== 4'b1100 || o_mwdata !== 32'h5678_5678 || o_mwe !== 1'b1 || o_maddr !== 32'h4) begin
      n_bad++;
      $display("FAIL sh_lanes: strb=%b wdata=%h we=%b addr=%h required 1100/56785678/1/00000004",
               o_mstrb, o_mwdata, o_mwe, o_maddr);
    end
    n_cmp++;
    if (o_done !== 1 || o_done_cyc !== 2 || o_wr !== 0 || o_busy !== 2) begin
      n_bad++;
      $display("FAIL sh_done: done=%0d@%0d wr=%0d busy=%0d required 1@2/0/2", o_done, o_done_cyc, o_wr, o_busy);
    end
  endtask

  task automatic test_errors();
    run_access(1'b0, 3'b010, 32'h0000_0001, 32'h0, 5'd4, 32'h0, 0);
    n_cmp++;
    if (o_req !== 0 || o_err !== 1 || o_err_cyc !== 1 || o_wr !== 0 || o_done !== 0 || o_busy !== 2) begin
      n_bad++;
      $display("FAIL misaligned_lw: req=%0d err=%0d@%0d wr=%0d done=%0d busy=%0d required 0/1@1/0/0/2",
               o_req, o_err, o_err_cyc, o_wr, o_done, o_busy);
    end
    run_access(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd4, 32'h0, 0);
    n_cmp++;
    if (o_req !== 0 || o_err !== 1 || o_err_cyc !== 1 || o_wr !== 0 || o_done !== 0 || o_busy !== 2) begin
      n_bad++;
      $display("FAIL illegal_f3: req=%0d err=%0d@%0d wr=%0d done=%0d busy=%0d required 0/1@1/0/0/2",
               o_req, o_err, o_err_cyc, o_wr, o_done, o_busy);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6, 32'h0, -1);
    n_cmp++;
    if (o_req !== TO || o_err !== 1 || o_err_cyc !== TO + 1 || o_wr !== 0 || o_done !== 0) begin
      n_bad++;
      $display("FAIL timeout: req=%0d err=%0d@%0d wr=%0d done=%0d required %0d/1@%0d/0/0",
               o_req, o_err, o_err_cyc, o_wr, o_done, TO, TO + 1);
    end
    run_access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd6, 32'hCAFE_F00D, 1);
    n_cmp++;
    if (o_wr !== 1 || o_wr_data !== 32'hCAFE_F00D || o_done !== 1) begin
      n_bad++;
      $display("FAIL after_timeout: wr=%0d data=%h done=%0d required 1/cafef00d/1", o_wr, o_wr_data, o_done);
    end
  endtask

  task automatic test_reset_mid_bus();
    int bad_pulse;
    @(negedge adc_sck);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_rd = 5'd7;
    @(negedge adc_sck);
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre: mem_req=%b required 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_async: mem_req=%b busy=%b addr=%h required 0/0/00000000", mem_req, busy, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    bad_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge adc_sck);
      if (i == 1) reset = 1'b1;
      #1;
      if (wr_en || done || err || mem_req) bad_pulse++;
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (bad_pulse !== 0) begin n_bad++; $display("FAIL rst_no_wb: %0d cycles with activity, required 0", bad_pulse); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle: busy=%b required 0", busy); end
    run_access(1'b0, 3'b000, 32'h0000_0081, 32'h0, 5'd7, 32'h0000_7F00, 0);
    n_cmp++;
    if (o_wr_data !== 32'h0000_007F || o_wr_addr !== 5'd7) begin
      n_bad++; $display("FAIL rst_recover: data=%h addr=%0d required 0000007f/7", o_wr_data, o_wr_addr);
    end
  endtask

  task automatic test_rd_zero();
    run_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 32'h1234_5678, 1);
    n_cmp++;
    if (o_wr !== 0 || o_done !== 1 || o_done_cyc !== 3) begin
      n_bad++; $display("FAIL rd_zero: wr=%0d done=%0d@%0d required 0/1@3", o_wr, o_done, o_done_cyc);
    end
  endtask

  task automatic test_random();
    logic st, lg;
    logic [2:0] f3;
    logic [31:0] a, wd, rdat;
    logic [4:0] rd;
    int dly, exp_busy;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom; rdat = $urandom;
      rd = 5'($urandom_range(0, 31)); dly = $urandom_range(0, TO - 1);
      if (n % 2 == 0) a[1:0] = 2'b00;
      if (n % 3 == 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'(3'b000 | ($urandom_range(0, 1) << 2));
      lg = m_legal(st, f3, a);
      run_access(st, f3, a, wd, rd, rdat, dly);
      exp_busy = !lg ? 2 : (st ? dly + 2 : dly + 3);
      n_cmp++;
      if (o_busy !== exp_busy || o_err !== int'(!lg) || o_done !== int'(lg) ||
          o_req !== (lg ? dly + 1 : 0) || o_unstable !== 1'b0) begin
        n_bad++;
        $display("FAIL rand%0d_ctrl st=%b f3=%b a=%h: busy=%0d err=%0d done=%0d req=%0d unstable=%b required %0d/%0d/%0d/%0d/0",
                 n, st, f3, a, o_busy, o_err, o_done, o_req, o_unstable,
                 exp_busy, int'(!lg), int'(lg), lg ? dly + 1 : 0);
      end
      if (lg) begin
        n_cmp++;
        if (o_maddr !== {a[31:2], 2'b00} || o_mwe !== st) begin
          n_bad++;
          $display("FAIL rand%0d_bus: addr=%h we=%b required %h/%b", n, o_maddr, o_mwe, {a[31:2], 2'b00}, st);
        end
        if (st) begin
          n_cmp++;
          if (o_mstrb !== m_strb(f3, a) || o_mwdata !== m_wdata(f3, wd) || o_wr !== 0) begin
            n_bad++;
            $display("FAIL rand%0d_store: strb=%b wdata=%h wr=%0d required %b/%h/0",
                     n, o_mstrb, o_mwdata, o_wr, m_strb(f3, a), m_wdata(f3, wd));
          end
        end else begin
          n_cmp++;
          if (o_wr !== int'(rd != 0) || (rd != 0 && (o_wr_addr !== rd || o_wr_data !== m_load(f3, a, rdat)))) begin
            n_bad++;
            $display("FAIL rand%0d_load f3=%b a=%h rdata=%h: wr=%0d addr=%0d data=%h required %0d/%0d/%h",
                     n, f3, a, rdat, o_wr, o_wr_addr, o_wr_data, int'(rd != 0), rd, m_load(f3, a, rdat));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb_delayed();
    test_lhu_immediate();
    test_sh();
    test_errors();
    test_timeout();
    test_reset_mid_bus();
    test_rd_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
